// File: rtl/iq16qam_pkg.sv
// Shared constants, FSM state type and Gray level lookup for the 16-QAM TX path.
package iq16qam_pkg;

   // Outer / inner constellation magnitudes; outer negative level is -(LVL_HI+1).
   localparam int LVL_HI = 1023;
   localparam int LVL_LO = 342;

   // Symbols per 128-bit payload word.
   localparam int unsigned NSYM = 32;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Per-axis Gray mapping: 00 -> -(hi+1), 01 -> -lo, 11 -> +lo, 10 -> +hi.
   function automatic int gray_lvl(input logic [1:0] g, input int hi, input int lo);
      int lvl;
      case (g)
         2'b00:   lvl = -(hi + 1);
         2'b01:   lvl = -lo;
         2'b11:   lvl = lo;
         default: lvl = hi;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/qam16_lvl_enc.sv
// Combinational 4-bit symbol to signed I/Q level encoder (I = sym[3:2], Q = sym[1:0]).
module qam16_lvl_enc #(
   parameter int unsigned SYM_W  = 11,
   parameter int          LVL_HI = iq16qam_pkg::LVL_HI,
   parameter int          LVL_LO = iq16qam_pkg::LVL_LO
) (
   input  logic [3:0]              sym_i,
   output logic signed [SYM_W-1:0] ar_o,
   output logic signed [SYM_W-1:0] ai_o
);

   import iq16qam_pkg::*;

   // Constant selection per axis, truncated to the output width.
   always_comb begin
      ar_o = SYM_W'(gray_lvl(sym_i[3:2], LVL_HI, LVL_LO));
      ai_o = SYM_W'(gray_lvl(sym_i[1:0], LVL_HI, LVL_LO));
   end

endmodule

// File: rtl/iqmap_16qam.sv
// 16-QAM TX mapper: accepts payload words, emits one Gray-mapped I/Q symbol per enabled clock, MSB first.
module iqmap_16qam #(
   parameter int unsigned WORD_W = 128,
   parameter int unsigned SYM_W  = 11,
   parameter int          LVL_HI = iq16qam_pkg::LVL_HI,
   parameter int          LVL_LO = iq16qam_pkg::LVL_LO
) (
   input  logic                    ck,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    valid_i,
   input  logic [WORD_W-1:0]       data_i,
   output logic                    ready_o,
   output logic                    valid_o,
   output logic signed [SYM_W-1:0] ar,
   output logic signed [SYM_W-1:0] ai,
   output logic [3:0]              sym_o,
   output logic                    last_o
);

   import iq16qam_pkg::*;

   localparam int unsigned    NSYM     = WORD_W / 4;
   localparam int unsigned    CNT_W    = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSYM - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0]       shreg_q, shreg_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic [3:0]              sym_q, sym_d;
   logic signed [SYM_W-1:0] ar_q, ar_d;
   logic signed [SYM_W-1:0] ai_q, ai_d;
   logic signed [SYM_W-1:0] enc_ar, enc_ai;
   logic                    accept;
   logic                    load;

   // Ready while idle or while the final symbol of the current word is on the outputs.
   always_comb begin
      ready_o = (state_q == IDLE) || (cnt_q == CNT_LAST);
      accept  = valid_i && ready_o && ce;
   end

   // Levels for the symbol about to be registered; outputs stay registered.
   qam16_lvl_enc #(
      .SYM_W  (SYM_W),
      .LVL_HI (LVL_HI),
      .LVL_LO (LVL_LO)
   ) u_enc (
      .sym_i (sym_d),
      .ar_o  (enc_ar),
      .ai_o  (enc_ai)
   );

   // Next-state / output computation; everything holds when ce is low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      valid_d = valid_q;
      last_d  = last_q;
      sym_d   = sym_q;
      ar_d    = ar_q;
      ai_d    = ai_q;
      load    = 1'b0;

      if (ce) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  load = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  sym_d   = '0;
               end
            end
            SEND: begin
               if (cnt_q == CNT_LAST) begin
                  if (accept) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                     sym_d   = '0;
                  end
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  sym_d   = shreg_q[WORD_W-1 -: 4];
                  shreg_d = shreg_q << 4;
                  last_d  = (cnt_q == CNT_LAST - 1'b1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // Symbol 0 goes straight to the outputs; the shift register keeps only the rest.
         if (load) begin
            state_d = SEND;
            cnt_d   = '0;
            shreg_d = data_i << 4;
            sym_d   = data_i[WORD_W-1 -: 4];
            valid_d = 1'b1;
            last_d  = (CNT_LAST == '0);
         end

         ar_d = valid_d ? enc_ar : '0;
         ai_d = valid_d ? enc_ai : '0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         sym_q   <= '0;
         ar_q    <= '0;
         ai_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         sym_q   <= sym_d;
         ar_q    <= ar_d;
         ai_q    <= ai_d;
      end
   end

   // Port drive from the output registers.
   always_comb begin
      valid_o = valid_q;
      last_o  = last_q;
      sym_o   = sym_q;
      ar      = ar_q;
      ai      = ai_q;
   end

endmodule
